// File: rtl/adder_share_arbiter.sv
// Purpose: round-robin time-sharing of one external WIDTH-bit adder between NUM_REQ requesters.
// Latency: grant -> rsp_valid is ADD_LAT+2 cycles; one operation per ADD_LAT+3 cycles at best.
// Backpressure: response held stable until rsp_ready; no request is accepted until then.
module adder_share_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int WIDTH   = 8,
  parameter int ADD_LAT = 1,
  parameter int ID_W    = 2
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [NUM_REQ-1:0]       req_valid,
  output logic [NUM_REQ-1:0]       req_ready,
  input  logic [NUM_REQ*WIDTH-1:0] req_a,
  input  logic [NUM_REQ*WIDTH-1:0] req_b,
  output logic [WIDTH-1:0]         add_a,
  output logic [WIDTH-1:0]         add_b,
  input  logic [WIDTH-1:0]         add_x,
  output logic                     rsp_valid,
  input  logic                     rsp_ready,
  output logic [ID_W-1:0]          rsp_id,
  output logic [WIDTH-1:0]         rsp_data,
  output logic                     busy
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_RESP = 2'd2
  } state_t;

  state_t           state_q;
  logic [ID_W-1:0]  last_q;
  logic [2:0]       cnt_q;
  logic [WIDTH-1:0] add_a_q;
  logic [WIDTH-1:0] add_b_q;
  logic             rsp_vld_q;
  logic [ID_W-1:0]  rsp_id_q;
  logic [WIDTH-1:0] rsp_dat_q;

  logic             gnt_vld;
  logic [ID_W-1:0]  gnt_idx;
  logic [ID_W-1:0]  cand;

  // Round-robin search: first valid requester after the last one granted, wrapping.
  always_comb begin
    gnt_vld = 1'b0;
    gnt_idx = '0;
    cand    = '0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      cand = ID_W'((int'(last_q) + k) % NUM_REQ);
      if (!gnt_vld && req_valid[cand]) begin
        gnt_vld = 1'b1;
        gnt_idx = cand;
      end
    end
  end

  // One-hot accept, only while idle and out of reset; never latched.
  always_comb begin
    req_ready = '0;
    if (reset && (state_q == S_IDLE) && gnt_vld) begin
      req_ready[gnt_idx] = 1'b1;
    end
  end

  // Control FSM with registered adder operands and response outputs.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= S_IDLE;
      last_q    <= ID_W'(NUM_REQ - 1);
      cnt_q     <= '0;
      add_a_q   <= '0;
      add_b_q   <= '0;
      rsp_vld_q <= 1'b0;
      rsp_id_q  <= '0;
      rsp_dat_q <= '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (gnt_vld) begin
            add_a_q  <= req_a[int'(gnt_idx)*WIDTH +: WIDTH];
            add_b_q  <= req_b[int'(gnt_idx)*WIDTH +: WIDTH];
            rsp_id_q <= gnt_idx;
            last_q   <= gnt_idx;
            cnt_q    <= 3'(ADD_LAT);
            state_q  <= S_WAIT;
          end
        end
        S_WAIT: begin
          // Operands stay put; the adder result is taken once the latency has elapsed.
          if (cnt_q == 3'd0) begin
            rsp_dat_q <= add_x;
            rsp_vld_q <= 1'b1;
            state_q   <= S_RESP;
          end else begin
            cnt_q <= cnt_q - 3'd1;
          end
        end
        S_RESP: begin
          if (rsp_ready) begin
            rsp_vld_q <= 1'b0;
            state_q   <= S_IDLE;
          end
        end
        default: begin
          state_q   <= S_IDLE;
          rsp_vld_q <= 1'b0;
        end
      endcase
    end
  end

  assign add_a     = add_a_q;
  assign add_b     = add_b_q;
  assign rsp_valid = rsp_vld_q;
  assign rsp_id    = rsp_id_q;
  assign rsp_data  = rsp_dat_q;
  assign busy      = (state_q != S_IDLE);

endmodule

// File: tb/tb_adder_share_arbiter.sv
// Purpose: directed self-checking bench for adder_share_arbiter (ADD_LAT=1 and ADD_LAT=3 instances).
// Latency: adder modelled as ADD_LAT register stages on add_a+add_b.
// Backpressure: rsp_ready driven per scenario.
module tb_adder_share_arbiter;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Instance with ADD_LAT=1
  logic        rst0;
  logic [3:0]  rv0, rdy0;
  logic [31:0] ra0, rb0;
  logic [7:0]  aa0, ab0, ax0, dat0;
  logic        vld0, rr0, busy0;
  logic [1:0]  id0;

  // Instance with ADD_LAT=3
  logic        rst3;
  logic [3:0]  rv3, rdy3;
  logic [31:0] ra3, rb3;
  logic [7:0]  aa3, ab3, ax3, dat3;
  logic        vld3, rr3, busy3;
  logic [1:0]  id3;

  adder_share_arbiter #(.NUM_REQ(4), .WIDTH(8), .ADD_LAT(1), .ID_W(2)) u_dut0 (
    .clk(clk), .reset(rst0), .req_valid(rv0), .req_ready(rdy0), .req_a(ra0), .req_b(rb0),
    .add_a(aa0), .add_b(ab0), .add_x(ax0), .rsp_valid(vld0), .rsp_ready(rr0),
    .rsp_id(id0), .rsp_data(dat0), .busy(busy0)
  );

  adder_share_arbiter #(.NUM_REQ(4), .WIDTH(8), .ADD_LAT(3), .ID_W(2)) u_dut3 (
    .clk(clk), .reset(rst3), .req_valid(rv3), .req_ready(rdy3), .req_a(ra3), .req_b(rb3),
    .add_a(aa3), .add_b(ab3), .add_x(ax3), .rsp_valid(vld3), .rsp_ready(rr3),
    .rsp_id(id3), .rsp_data(dat3), .busy(busy3)
  );

  // Adder models: result appears ADD_LAT cycles after the operands
  logic [7:0] p0 = 8'd0;
  logic [7:0] p3a = 8'd0, p3b = 8'd0, p3c = 8'd0;
  always @(posedge clk) begin
    p0  <= aa0 + ab0;
    p3a <= aa3 + ab3;
    p3b <= p3a;
    p3c <= p3b;
  end
  assign ax0 = p0;
  assign ax3 = p3c;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Runs one operation on the ADD_LAT=1 instance; returns at the first rsp_valid cycle.
  task automatic serve0(output int g, output int wait_c, output int lat,
                        output logic [1:0] id, output logic [7:0] d, output bit rdy_bad);
    g = -1; wait_c = 0; lat = 0; id = '0; d = '0; rdy_bad = 1'b0;
    #1;
    for (int c = 0; c < 16 && g < 0; c++) begin
      if (!$onehot0(rdy0)) rdy_bad = 1'b1;
      if (rdy0 != 4'd0) begin
        for (int i = 0; i < 4; i++) if (rdy0[i]) g = i;
      end else begin
        step();
        wait_c++;
      end
    end
    if (g < 0) return;
    step();
    lat = 1;
    while (!vld0 && lat < 16) begin
      if (rdy0 != 4'd0) rdy_bad = 1'b1;
      step();
      lat++;
    end
    id = id0;
    d  = dat0;
  endtask

  task automatic test_reset();
    rst0 = 1'b0; rst3 = 1'b0;
    rv0 = 4'hF; rv3 = 4'hF; rr0 = 1'b1; rr3 = 1'b1;
    ra0 = '0; rb0 = '0; ra3 = '0; rb3 = '0;
    repeat (4) step();
    checks++; if (rdy0 !== 4'd0) begin errors++; $display("FAIL reset_req_ready got %h want 0", rdy0); end
    checks++; if (aa0 !== 8'd0 || ab0 !== 8'd0) begin errors++; $display("FAIL reset_add got %0d/%0d want 0/0", aa0, ab0); end
    checks++; if (vld0 !== 1'b0 || busy0 !== 1'b0) begin errors++; $display("FAIL reset_vld_busy got %b/%b want 0/0", vld0, busy0); end
    checks++; if (id0 !== 2'd0 || dat0 !== 8'd0) begin errors++; $display("FAIL reset_rsp got %0d/%0d want 0/0", id0, dat0); end
    checks++; if (rdy3 !== 4'd0 || busy3 !== 1'b0) begin errors++; $display("FAIL reset_dut3 got %h/%b want 0/0", rdy3, busy3); end
    rv0 = 4'd0; rv3 = 4'd0;
    step();
    rst0 = 1'b1; rst3 = 1'b1;
    step();
  endtask

  task automatic test_all_four();
    int g, w, lat; logic [1:0] id; logic [7:0] d; bit bad;
    ra0 = {8'd3, 8'd2, 8'd1, 8'd0};
    rb0 = {8'd30, 8'd20, 8'd10, 8'd0};
    rr0 = 1'b1;
    rv0 = 4'hF;
    for (int k = 0; k < 4; k++) begin
      serve0(g, w, lat, id, d, bad);
      checks++; if (g != k) begin errors++; $display("FAIL all4_grant got %0d want %0d", g, k); end
      checks++; if (id !== 2'(k) || d !== 8'(11*k)) begin errors++; $display("FAIL all4_rsp got id %0d data %0d want id %0d data %0d", id, d, k, 11*k); end
      checks++; if (lat != 3 || bad) begin errors++; $display("FAIL all4_lat got lat %0d onehot_err %0b want lat 3 onehot_err 0", lat, bad); end
      checks++; if (w != ((k == 0) ? 0 : 1)) begin errors++; $display("FAIL all4_throughput got wait %0d want %0d", w, (k == 0) ? 0 : 1); end
      if (g >= 0) rv0[g] = 1'b0;
    end
    step();
    checks++; if (busy0 !== 1'b0 || vld0 !== 1'b0) begin errors++; $display("FAIL all4_idle got busy %b vld %b want 0 0", busy0, vld0); end
  endtask

  task automatic test_single();
    ra0[23:16] = 8'd5; rb0[23:16] = 8'd7; rr0 = 1'b1;
    rv0 = 4'b0100;
    #1;
    checks++; if (rdy0 !== 4'b0100) begin errors++; $display("FAIL single_ready got %b want 0100", rdy0); end
    step();
    rv0 = 4'd0;
    #1;
    checks++; if (aa0 !== 8'd5 || ab0 !== 8'd7) begin errors++; $display("FAIL single_operands got %0d/%0d want 5/7", aa0, ab0); end
    checks++; if (rdy0 !== 4'd0 || busy0 !== 1'b1 || vld0 !== 1'b0) begin errors++; $display("FAIL single_wait got rdy %b busy %b vld %b want 0000 1 0", rdy0, busy0, vld0); end
    step();
    checks++; if (vld0 !== 1'b0) begin errors++; $display("FAIL single_early_vld got %b want 0", vld0); end
    step();
    checks++; if (vld0 !== 1'b1 || id0 !== 2'd2 || dat0 !== 8'd12) begin errors++; $display("FAIL single_rsp got vld %b id %0d data %0d want 1 2 12", vld0, id0, dat0); end
    step();
    checks++; if (vld0 !== 1'b0 || busy0 !== 1'b0) begin errors++; $display("FAIL single_done got vld %b busy %b want 0 0", vld0, busy0); end
  endtask

  task automatic test_overflow();
    int g, w, lat; logic [1:0] id; logic [7:0] d; bit bad;
    ra0[31:24] = 8'd200; rb0[31:24] = 8'd100; rv0 = 4'b1000;
    serve0(g, w, lat, id, d, bad);
    checks++; if (g != 3 || id !== 2'd3 || d !== 8'd44) begin errors++; $display("FAIL ovf_200_100 got g %0d id %0d data %0d want 3 3 44", g, id, d); end
    rv0 = 4'd0;
    step();
    ra0[7:0] = 8'd255; rb0[7:0] = 8'd1; rv0 = 4'b0001;
    serve0(g, w, lat, id, d, bad);
    checks++; if (g != 0 || id !== 2'd0 || d !== 8'd0) begin errors++; $display("FAIL ovf_255_1 got g %0d id %0d data %0d want 0 0 0", g, id, d); end
    rv0 = 4'd0;
    step();
  endtask

  task automatic test_backpressure();
    int g, w, lat; logic [1:0] id; logic [7:0] d; bit bad;
    ra0[15:8] = 8'd3;  rb0[15:8] = 8'd4;
    ra0[23:16] = 8'd50; rb0[23:16] = 8'd60;
    rr0 = 1'b0;
    rv0 = 4'b0110;
    serve0(g, w, lat, id, d, bad);
    checks++; if (g != 1 || id !== 2'd1 || d !== 8'd7) begin errors++; $display("FAIL bp_first got g %0d id %0d data %0d want 1 1 7", g, id, d); end
    rv0[1] = 1'b0;
    for (int i = 0; i < 5; i++) begin
      step();
      checks++;
      if (vld0 !== 1'b1 || id0 !== 2'd1 || dat0 !== 8'd7 || rdy0 !== 4'd0) begin
        errors++; $display("FAIL bp_hold cycle %0d got vld %b id %0d data %0d rdy %b want 1 1 7 0000", i, vld0, id0, dat0, rdy0);
      end
    end
    rr0 = 1'b1;
    #1;
    checks++; if (rdy0 !== 4'd0) begin errors++; $display("FAIL bp_handshake_ready got %b want 0000", rdy0); end
    step();
    checks++; if (rdy0 !== 4'b0100 || vld0 !== 1'b0) begin errors++; $display("FAIL bp_second_grant got rdy %b vld %b want 0100 0", rdy0, vld0); end
    serve0(g, w, lat, id, d, bad);
    checks++; if (g != 2 || w != 0 || d !== 8'd110 || lat != 3) begin errors++; $display("FAIL bp_second got g %0d wait %0d data %0d lat %0d want 2 0 110 3", g, w, d, lat); end
    rv0 = 4'd0;
    step();
  endtask

  task automatic test_fairness();
    int g, w, lat, prev, expg; logic [1:0] id; logic [7:0] d, expd; bit bad;
    ra0[7:0] = 8'd1;   rb0[7:0] = 8'd1;
    ra0[23:16] = 8'd2; rb0[23:16] = 8'd2;
    rr0 = 1'b1;
    rv0 = 4'b0101;
    prev = -1;
    for (int k = 0; k < 8; k++) begin
      expg = (k % 2 == 0) ? 0 : 2;
      expd = ra0[expg*8 +: 8] + rb0[expg*8 +: 8];
      serve0(g, w, lat, id, d, bad);
      checks++;
      if (g != expg || g == prev || d !== expd || id !== 2'(expg)) begin
        errors++; $display("FAIL fair op %0d got g %0d id %0d data %0d want g %0d data %0d", k, g, id, d, expg, expd);
      end
      prev = g;
      if (g >= 0) begin
        ra0[g*8 +: 8] = 8'(k*3 + 1);
        rb0[g*8 +: 8] = 8'(k*5 + 100);
      end
    end
    rv0 = 4'd0;
    step();
  endtask

  task automatic test_reset_mid_wait();
    int lat; bit stale;
    ra3[15:8] = 8'd10; rb3[15:8] = 8'd20; rr3 = 1'b1;
    rv3 = 4'b0010;
    #1;
    checks++; if (rdy3 !== 4'b0010) begin errors++; $display("FAIL rst_mid_grant got %b want 0010", rdy3); end
    step();
    rv3 = 4'd0;
    step();
    rst3 = 1'b0;
    #1;
    checks++; if (aa3 !== 8'd0 || ab3 !== 8'd0 || vld3 !== 1'b0 || busy3 !== 1'b0 || id3 !== 2'd0) begin
      errors++; $display("FAIL rst_mid_clear got add %0d/%0d vld %b busy %b id %0d want 0/0 0 0 0", aa3, ab3, vld3, busy3, id3);
    end
    step(); step();
    rst3 = 1'b1;
    stale = 1'b0;
    for (int i = 0; i < 8; i++) begin
      step();
      if (vld3 !== 1'b0 || busy3 !== 1'b0) stale = 1'b1;
    end
    checks++; if (stale) begin errors++; $display("FAIL rst_mid_stale got stale activity 1 want 0"); end
    ra3[7:0] = 8'd40; rb3[7:0] = 8'd2; ra3[15:8] = 8'd7; rb3[15:8] = 8'd7;
    rv3 = 4'b0011;
    #1;
    checks++; if (rdy3 !== 4'b0001) begin errors++; $display("FAIL rst_mid_prio got %b want 0001", rdy3); end
    step();
    rv3 = 4'd0;
    lat = 1;
    while (!vld3 && lat < 16) begin step(); lat++; end
    checks++; if (lat != 5 || id3 !== 2'd0 || dat3 !== 8'd42) begin
      errors++; $display("FAIL rst_mid_op got lat %0d id %0d data %0d want 5 0 42", lat, id3, dat3);
    end
    step();
    checks++; if (vld3 !== 1'b0 || busy3 !== 1'b0) begin errors++; $display("FAIL rst_mid_done got vld %b busy %b want 0 0", vld3, busy3); end
  endtask

  initial begin
    test_reset();
    test_all_four();
    test_single();
    test_overflow();
    test_backpressure();
    test_fairness();
    test_reset_mid_wait();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog got timeout want completion");
    $fatal(1, "watchdog");
  end

endmodule
